// File: rtl/uart_calc_ctrl.sv
// Byte-stream calculator controller: assembles A, B and opcode from UART bytes, drives an
// external ALU and returns the result LSB first. Define UART_CALC_HI_EN to also return alu_hi.
module uart_calc_ctrl #(
    parameter int WIDTH          = 32,
    parameter int OP_BITS        = 4,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         rx_byte,
    input  logic               rx_valid,
    output logic [7:0]         tx_byte,
    output logic               tx_send,
    input  logic               tx_done,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [OP_BITS-1:0] alu_op,
    input  logic [WIDTH-1:0]   alu_lo,
    input  logic [WIDTH-1:0]   alu_hi,
    output logic               busy,
    output logic [2:0]         state,
    output logic               err_timeout,
    output logic               rx_overrun
);

    typedef enum logic [2:0] {
        RX_A  = 3'd0,
        RX_B  = 3'd1,
        RX_OP = 3'd2,
        EXEC  = 3'd3,
        TX    = 3'd4
    } state_t;

`ifdef UART_CALC_HI_EN
    localparam int SH_W = 2 * WIDTH;
`else
    localparam int SH_W = WIDTH;
`endif
    localparam int BYTES    = WIDTH / 8;
    localparam int TX_BYTES = SH_W / 8;
    localparam int GAP_W    = $clog2(TIMEOUT_CYCLES);

    localparam logic [2:0]       LAST_BYTE = 3'(BYTES - 1);
    localparam logic [3:0]       LAST_TX   = 4'(TX_BYTES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q;
    logic [2:0]        byte_cnt;
    logic [3:0]        tx_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [SH_W-1:0]   tx_shift;
    logic [SH_W-1:0]   result_word;
    logic              partial;
    logic              expire;

`ifdef UART_CALC_HI_EN
    assign result_word = {alu_hi, alu_lo};
`else
    logic unused_hi;
    assign unused_hi   = ^alu_hi;
    assign result_word = alu_lo;
`endif

    // A frame is "partial" once its first byte has arrived and until the opcode byte lands.
    assign partial = ((state_q == RX_A) && (byte_cnt != 3'd0)) ||
                     (state_q == RX_B) || (state_q == RX_OP);
    assign expire  = partial && (gap_cnt == GAP_LAST);

    assign tx_byte = tx_shift[7:0];
    assign busy    = (state_q == EXEC) || (state_q == TX);
    assign state   = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RX_A;
            byte_cnt    <= '0;
            tx_cnt      <= '0;
            gap_cnt     <= '0;
            tx_shift    <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= '0;
            tx_send     <= 1'b0;
            err_timeout <= 1'b0;
            rx_overrun  <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout; strobes default low here so every pulse lasts one cycle.
            tx_send     <= 1'b0;
            err_timeout <= 1'b0;
            rx_overrun  <= 1'b0;

            if (!partial || rx_valid) begin
                gap_cnt <= '0;
            end else begin
                gap_cnt <= gap_cnt + 1'b1;
            end

            if (expire) begin
                // Timeout beats a simultaneous rx_valid: the byte is dropped silently.
                err_timeout <= 1'b1;
                byte_cnt    <= '0;
                gap_cnt     <= '0;
                state_q     <= RX_A;
            end else begin
                case (state_q)
                    RX_A: begin
                        if (rx_valid) begin
                            alu_a[{byte_cnt, 3'b000} +: 8] <= rx_byte;
                            if (byte_cnt == LAST_BYTE) begin
                                byte_cnt <= '0;
                                state_q  <= RX_B;
                            end else begin
                                byte_cnt <= byte_cnt + 1'b1;
                            end
                        end
                    end
                    RX_B: begin
                        if (rx_valid) begin
                            alu_b[{byte_cnt, 3'b000} +: 8] <= rx_byte;
                            if (byte_cnt == LAST_BYTE) begin
                                byte_cnt <= '0;
                                state_q  <= RX_OP;
                            end else begin
                                byte_cnt <= byte_cnt + 1'b1;
                            end
                        end
                    end
                    RX_OP: begin
                        if (rx_valid) begin
                            alu_op  <= rx_byte[OP_BITS-1:0];
                            state_q <= EXEC;
                        end
                    end
                    EXEC: begin
                        tx_shift   <= result_word;
                        tx_cnt     <= '0;
                        tx_send    <= 1'b1;
                        rx_overrun <= rx_valid;
                        state_q    <= TX;
                    end
                    TX: begin
                        rx_overrun <= rx_valid;
                        // tx_done cannot legitimately coincide with our own send strobe.
                        if (tx_done && !tx_send) begin
                            tx_shift <= tx_shift >> 8;
                            if (tx_cnt == LAST_TX) begin
                                tx_cnt  <= '0;
                                state_q <= RX_A;
                            end else begin
                                tx_cnt  <= tx_cnt + 1'b1;
                                tx_send <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        byte_cnt <= '0;
                        state_q  <= RX_A;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_calc_ctrl.sv
// Directed bench for uart_calc_ctrl: 32-bit instance with a tx_done responder plus an 8-bit
// instance for single-byte capture. Expected bytes follow UART_CALC_HI_EN when defined.
module tb_uart_calc_ctrl;

`ifdef UART_CALC_HI_EN
    localparam int TXB = 8;
`else
    localparam int TXB = 4;
`endif
    localparam int DONE_DLY = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic [7:0]  tx_byte;
    logic        tx_send;
    logic        tx_done;
    logic [31:0] alu_a, alu_b, alu_lo, alu_hi;
    logic [3:0]  alu_op;
    logic        busy;
    logic [2:0]  state;
    logic        err_timeout;
    logic        rx_overrun;

    logic [7:0]  rx_byte8;
    logic        rx_valid8;
    logic        tx_done8;
    logic [7:0]  tx_byte8, alu_a8, alu_b8, alu_lo8, alu_hi8;
    logic        tx_send8, busy8, err_timeout8, rx_overrun8;
    logic [3:0]  alu_op8;
    logic [2:0]  state8;

    int tests = 0;
    int fails = 0;
    int viol  = 0;
    logic [7:0] sent_q[$];

    always #5 clk = ~clk;

    uart_calc_ctrl #(.WIDTH(32), .OP_BITS(4), .TIMEOUT_CYCLES(50)) u_dut (
        .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .tx_byte(tx_byte), .tx_send(tx_send), .tx_done(tx_done),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_lo(alu_lo), .alu_hi(alu_hi),
        .busy(busy), .state(state), .err_timeout(err_timeout), .rx_overrun(rx_overrun)
    );

    uart_calc_ctrl #(.WIDTH(8), .OP_BITS(4), .TIMEOUT_CYCLES(50)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte8), .rx_valid(rx_valid8),
        .tx_byte(tx_byte8), .tx_send(tx_send8), .tx_done(tx_done8),
        .alu_a(alu_a8), .alu_b(alu_b8), .alu_op(alu_op8), .alu_lo(alu_lo8), .alu_hi(alu_hi8),
        .busy(busy8), .state(state8), .err_timeout(err_timeout8), .rx_overrun(rx_overrun8)
    );

    // ALU stubs: op 1 subtracts, anything else adds; hi is a XOR b.
    always_comb begin
        alu_lo  = (alu_op == 4'd1) ? (alu_a - alu_b) : (alu_a + alu_b);
        alu_hi  = alu_a ^ alu_b;
        alu_lo8 = alu_a8 + alu_b8;
        alu_hi8 = alu_a8 ^ alu_b8;
    end

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
        logic [31:0] lo;
        lo = (op == 4'd1) ? (a - b) : (a + b);
        return {a ^ b, lo};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // uart_tx stand-in: records each send and answers tx_done DONE_DLY cycles later.
    initial begin
        int   resp_cnt;
        logic prev_send;
        resp_cnt  = 0;
        prev_send = 1'b0;
        tx_done   = 1'b0;
        forever begin
            @(negedge clk);
            tx_done = 1'b0;
            if (!rst_n) begin
                resp_cnt  = 0;
                prev_send = 1'b0;
            end else begin
                if (tx_send && prev_send) viol++;
                prev_send = tx_send;
                if (resp_cnt > 0) begin
                    resp_cnt--;
                    if (resp_cnt == 0) tx_done = 1'b1;
                end else if (tx_send) begin
                    sent_q.push_back(tx_byte);
                    resp_cnt = DONE_DLY;
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] a, input logic [31:0] b, input logic [7:0] opb,
                              input string tag);
        sent_q.delete();
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
        for (int i = 0; i < 4; i++) send_byte(b[8*i +: 8]);
        send_byte(opb);
        check({tag, "_exec"}, state, 3);
        @(negedge clk);
        check({tag, "_tx_state"}, state, 4);
        check({tag, "_first_send"}, tx_send, 1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((state != 3'd0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle_in_time"}, (n < 3000), 1);
        check({tag, "_state_rx_a"}, state, 0);
    endtask

    task automatic finish_frame(input logic [31:0] a, input logic [31:0] b, input logic [7:0] opb,
                                input string tag);
        logic [63:0] exp;
        exp = model(a, b, opb[3:0]);
        wait_idle(tag);
        check({tag, "_alu_a"}, alu_a, a);
        check({tag, "_alu_b"}, alu_b, b);
        check({tag, "_alu_op"}, alu_op, opb[3:0]);
        check({tag, "_nbytes"}, sent_q.size(), TXB);
        for (int i = 0; i < TXB; i++)
            if (i < sent_q.size())
                check($sformatf("%s_byte%0d", tag, i), sent_q[i], exp[8*i +: 8]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_err;
        int pulses;
        int n;
        int sz;
        rst_n     = 1'b0;
        rx_byte   = 8'h00;
        rx_valid  = 1'b0;
        rx_byte8  = 8'h00;
        rx_valid8 = 1'b0;
        tx_done8  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", state, 0);
        check("rst_busy", busy, 0);
        check("rst_tx_send", tx_send, 0);
        check("rst_tx_byte", tx_byte, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_flags", {err_timeout, rx_overrun}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic addition frame.
        send_frame(32'h5, 32'h7, 8'h00, "add");
        finish_frame(32'h5, 32'h7, 8'h00, "add");

        // Subtraction with upper opcode bits set (ignored).
        send_frame(32'h1234_5678, 32'h0F0F_0F0F, 8'hF1, "sub");
        finish_frame(32'h1234_5678, 32'h0F0F_0F0F, 8'hF1, "sub");

        // Partial frame abandoned: timeout at gap cycle 50.
        send_byte(8'h11);
        send_byte(8'h22);
        first_err = 0;
        pulses    = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (err_timeout) begin
                pulses++;
                if (first_err == 0) first_err = k;
            end
        end
        check("to_cycle", first_err, 50);
        check("to_pulses", pulses, 1);
        check("to_state", state, 0);
        send_frame(32'h100, 32'h23, 8'h00, "post_to");
        finish_frame(32'h100, 32'h23, 8'h00, "post_to");

        // Byte arriving during TX is dropped with a one-cycle overrun pulse.
        send_frame(32'hDEAD_0001, 32'h0000_1111, 8'h00, "ovr");
        send_byte(8'hAA);
        check("ovr_pulse", rx_overrun, 1);
        @(negedge clk);
        check("ovr_pulse_end", rx_overrun, 0);
        finish_frame(32'hDEAD_0001, 32'h0000_1111, 8'h00, "ovr");
        send_frame(32'h1, 32'h2, 8'h00, "after_ovr");
        finish_frame(32'h1, 32'h2, 8'h00, "after_ovr");

        // Reset during TX after the second send.
        send_frame(32'hCAFE_F00D, 32'h0101_0101, 8'h00, "rst_mid");
        n = 0;
        while (sent_q.size() < 2 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_two_sends", sent_q.size(), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_state", state, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_tx_send", tx_send, 0);
        check("rst_mid_tx_byte", tx_byte, 0);
        check("rst_mid_operands", {alu_a, alu_b}, 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        sz = sent_q.size();
        repeat (300) @(negedge clk);
        check("rst_mid_no_more_sends", sent_q.size(), sz);
        check("rst_mid_still_idle", state, 0);
        send_frame(32'h0000_00FF, 32'h0000_0001, 8'h00, "post_rst");
        finish_frame(32'h0000_00FF, 32'h0000_0001, 8'h00, "post_rst");

        // 8-bit instance: single-byte operands and opcode masking.
        @(negedge clk);
        rx_byte8 = 8'h9A;
        rx_valid8 = 1'b1;
        @(negedge clk);
        rx_valid8 = 1'b0;
        check("w8_after_a", state8, 1);
        check("w8_alu_a", alu_a8, 8'h9A);
        rx_byte8 = 8'h11;
        rx_valid8 = 1'b1;
        @(negedge clk);
        rx_valid8 = 1'b0;
        check("w8_after_b", state8, 2);
        check("w8_alu_b", alu_b8, 8'h11);
        rx_byte8 = 8'hF3;
        rx_valid8 = 1'b1;
        @(negedge clk);
        rx_valid8 = 1'b0;
        check("w8_exec", state8, 3);
        check("w8_alu_op", alu_op8, 3);
        @(negedge clk);
        check("w8_send", tx_send8, 1);
        check("w8_tx_byte", tx_byte8, 8'hAB);

        check("no_back_to_back_send", viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_calc_ctrl.md
# uart_calc_ctrl

Parametrised byte-stream calculator controller. It sits between a `uart_rx`/`uart_tx` pair and an external `alu` instance. It assembles two WIDTH-bit operands and an opcode byte from received bytes, presents them to the ALU, then serialises the result back as bytes, least-significant byte (LSB) first. Compared with the fixed 32-bit calculator top, it adds configurable operand width, an inter-byte timeout with frame resynchronisation, overrun flagging, an optional high-word return and asynchronous reset.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width in bits; must be a multiple of 8, range 8..64
- `OP_BITS`, 4, opcode width taken from the low bits of the opcode byte; range 1..8
- `TIMEOUT_CYCLES`, 20000, maximum clk cycles allowed between bytes of one frame; must be ≥ 2

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `rx_byte`  in  8  received byte, valid when `rx_valid` is high
- `rx_valid`  in  1  one-cycle strobe from `uart_rx` `done`
- `tx_byte`  out  8  byte to transmit; held stable until the matching `tx_done`
- `tx_send`  out  1  one-cycle send strobe to `uart_tx`
- `tx_done`  in  1  one-cycle strobe from `uart_tx`: byte fully sent
- `alu_a`  out  WIDTH  operand A
- `alu_b`  out  WIDTH  operand B
- `alu_op`  out  OP_BITS  opcode
- `alu_lo`  in  WIDTH  ALU low result (combinational from `alu_a`/`alu_b`/`alu_op`)
- `alu_hi`  in  WIDTH  ALU high result
- `busy`  out  1  high in EXEC and TX
- `state`  out  3  current state encoding (debug)
- `err_timeout`  out  1  one-cycle pulse when a partial frame is discarded
- `rx_overrun`  out  1  one-cycle pulse when a byte is dropped in EXEC or TX

## Operation
- Frame format: WIDTH/8 bytes of A, then WIDTH/8 bytes of B, both LSB first, then 1 opcode byte. `alu_op` takes `rx_byte[OP_BITS-1:0]` of the opcode byte; the remaining bits are ignored.
- States and `state` encoding: RX_A = 0, RX_B = 1, RX_OP = 2, EXEC = 3, TX = 4. Encodings 5–7 are illegal and recover to RX_A.
- RX_A / RX_B:
  - Each `rx_valid` writes the byte into lane `byte_cnt` of the target operand and increments `byte_cnt`.
  - On the last byte, `byte_cnt` clears and the state advances.
- RX_OP: `rx_valid` latches `alu_op` and moves to EXEC.
- EXEC (exactly 1 cycle): latch `alu_lo` (and `alu_hi`, see Configuration) into the TX shift register. Set `tx_cnt` = 0 and go to TX.
- TX:
  - Drive `tx_byte` = shift register bits [7:0].
  - Pulse `tx_send` once per byte.
  - On `tx_done`: shift right by 8 and increment `tx_cnt`. After the last byte's `tx_done`, go to RX_A.
  - The next `tx_send` fires the cycle after `tx_done`.
- `alu_a`, `alu_b` and `alu_op` hold their values until overwritten by the next frame.
- Timeout:
  - Gap counter resets on every `rx_valid`.
  - It counts only while a frame is partial: RX_A with `byte_cnt` ≠ 0, or RX_B, or RX_OP.
  - When it reaches TIMEOUT_CYCLES: pulse `err_timeout`, clear `byte_cnt`, return to RX_A. Operand registers are not cleared.
- `rx_valid` in EXEC or TX: the byte is discarded and `rx_overrun` pulses for one cycle.
- `tx_done` outside TX: ignored.
- `rx_valid` in the same cycle the timeout expires: the timeout wins, the byte is discarded, and no overrun pulse is generated.

## Timing
- All outputs after `rst_n` low are 0: `tx_byte`, `tx_send`, `alu_a`, `alu_b`, `alu_op`, `busy`, `state` (RX_A), `err_timeout`, `rx_overrun`. `byte_cnt`, `tx_cnt` and the gap counter are also 0.
- Reset asserted mid-frame or mid-TX aborts immediately. No further `tx_send` is issued. `uart_tx` may finish its current byte.
- Latency:
  - `rx_valid` of the opcode byte at cycle N: EXEC at N+1, first `tx_send` at N+2.
  - Last `tx_done` at cycle M: `state` = RX_A at M+1.
- `tx_send` is never high for two consecutive cycles.
- At most one `tx_send` is outstanding without a matching `tx_done`.

## Configuration
- `UART_CALC_HI_EN` defined:
  - EXEC latches {`alu_hi`, `alu_lo`} into a 2·WIDTH shift register.
  - TX sends 2·WIDTH/8 bytes: the lo bytes LSB first, then the hi bytes LSB first.
- Not defined:
  - TX sends WIDTH/8 bytes of `alu_lo` only.
  - `alu_hi` is unused, and the shift register is WIDTH bits.

## Test plan
- WIDTH = 32, ALU stub with lo = a + b:
  - Send A = 0x00000005 as 05 00 00 00, B = 0x00000007, op byte 0x00.
  - Respond to each `tx_send` with `tx_done` 100 cycles later.
  - Expect `alu_a` = 5, `alu_b` = 7, and exactly four `tx_send` with bytes 0C 00 00 00, then `state` = 0.
- `UART_CALC_HI_EN`, WIDTH = 16, stub lo = 0x5678, hi = 0x1234: expect TX bytes 78 56 34 12, then return to RX_A.
- TIMEOUT_CYCLES = 50: send 2 bytes of A, then idle for 60 cycles.
  - Expect one `err_timeout` pulse at gap cycle 50 and `state` = 0.
  - A following full frame must compute correctly.
- Inject `rx_valid` during TX: expect a one-cycle `rx_overrun` pulse, TX bytes unchanged, and the following frame parsed from its first byte.
- Assert `rst_n` low mid-TX after the 2nd `tx_send`:
  - Expect all outputs 0 asynchronously and no further `tx_send`.
  - After release, a full frame works.
- WIDTH = 8, OP_BITS = 4, op byte 0xF3: expect `alu_op` = 3 and single-byte operand capture.
